hack_program_loader: RTL and testbench

Serial program loader for the Hack computer: receives a framed program image over a UART line and writes it word-by-word into the instruction memory the CPU fetches from. It holds the CPU in reset while a load is in progress and releases it only after a verified image. Sits between the board's RX pin and the write port of the instruction RAM that replaces the fixed instruction ROM.

---
 rtl/hack_program_loader_if.sv | 32 +++
 rtl/hack_program_loader.sv | 334 +++++++++++++++++++++++++++++++++
 tb/tb_hack_program_loader.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/hack_program_loader_if.sv
// -----------------------------------------------------------------------------
// hack_program_loader_if
//
// Write port of the Hack instruction RAM, as driven by the program loader.
//
//   rom_addr  instruction memory write address (ADDR_WIDTH bits)
//   rom_data  16-bit instruction word to write
//   rom_we    one-cycle write strobe; addr/data are valid while it is high
//
// Modports:
//   master  the loader, which drives the write port
//   slave   the instruction RAM, which receives it
// -----------------------------------------------------------------------------
interface hack_program_loader_if #(
    parameter int ADDR_WIDTH = 15
);
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [15:0]           rom_data;
    logic                  rom_we;

    modport master (
        output rom_addr,
        output rom_data,
        output rom_we
    );

    modport slave (
        input rom_addr,
        input rom_data,
        input rom_we
    );
endinterface

// File: rtl/hack_program_loader.sv
// -----------------------------------------------------------------------------
// hack_program_loader
//
// Serial program loader for the Hack computer. A UART receiver assembles bytes
// from the rx pin; a loader FSM parses the frame
//     0xA5, COUNT_HI, COUNT_LO, N x (DATA_HI, DATA_LO), CHK
// and writes each 16-bit word into the instruction RAM. The CPU is held in
// reset from the header until a frame with a matching checksum completes.
// CHK is the 8-bit wrapping sum of the count bytes and all data bytes.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per UART bit (>= 4)
//   ADDR_WIDTH    instruction memory address width
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   rx           UART serial input, idle high, asynchronous to clk
//   rom          instruction RAM write port (master side)
//   cpu_reset    drives the CPU reset input
//   loading      high while a frame is being received
//   word_count   words written in the current/last frame
//   frame_error  sticky: a low stop bit was seen
//   chk_error    sticky: bad checksum or illegal count
// -----------------------------------------------------------------------------
module hack_program_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    hack_program_loader_if.master rom,
    output logic                  cpu_reset,
    output logic                  loading,
    output logic [ADDR_WIDTH-1:0] word_count,
    output logic                  frame_error,
    output logic                  chk_error
);

    localparam int                CNT_W     = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0]        HEADER    = 8'hA5;

    // =========================================================================
    // UART receiver
    // =========================================================================
    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_WAIT
    } rx_state_t;

    logic             rx_s1_q, rx_s2_q, rx_prev_q;
    rx_state_t        rx_state_q, rx_state_d;
    logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]       rx_bit_q, rx_bit_d;
    logic [7:0]       rx_shift_q, rx_shift_d;
    logic             byte_valid_q, byte_valid_d;
    logic             byte_err_q, byte_err_d;

    // Two-flop synchronizer; rx_prev_q holds the previous synchronized level
    // so a start bit is recognised only on a genuine high-to-low transition.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_s1_q   <= 1'b1;
            rx_s2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_s1_q   <= rx;
            rx_s2_q   <= rx_s1_q;
            rx_prev_q <= rx_s2_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state_q   <= RX_IDLE;
            rx_cnt_q     <= '0;
            rx_bit_q     <= '0;
            rx_shift_q   <= '0;
            byte_valid_q <= 1'b0;
            byte_err_q   <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            rx_cnt_q     <= rx_cnt_d;
            rx_bit_q     <= rx_bit_d;
            rx_shift_q   <= rx_shift_d;
            byte_valid_q <= byte_valid_d;
            byte_err_q   <= byte_err_d;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_cnt_d     = rx_cnt_q + 1'b1;
        rx_bit_d     = rx_bit_q;
        rx_shift_d   = rx_shift_q;
        byte_valid_d = 1'b0;
        byte_err_d   = 1'b0;

        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_s2_q) begin
                    rx_state_d = RX_START;
                end
            end

            // Mid-point of the start bit: still low means a real start,
            // high means the falling edge was a glitch.
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s2_q ? RX_IDLE : RX_DATA;
                end
            end

            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 1'b1;
                    if (rx_bit_q == 3'd7) begin
                        rx_state_d = RX_STOP;
                    end
                end
            end

            // A good stop bit returns straight to idle so the very next
            // falling edge (a back-to-back start bit) is caught. A bad stop
            // bit must see the line high for a full bit time before rearming.
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_s2_q) begin
                        byte_valid_d = 1'b1;
                        rx_state_d   = RX_IDLE;
                    end else begin
                        byte_err_d = 1'b1;
                        rx_state_d = RX_WAIT;
                    end
                end
            end

            RX_WAIT: begin
                if (!rx_s2_q) begin
                    rx_cnt_d = '0;
                end else if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_state_d = RX_IDLE;
                end
            end

            default: begin
                rx_state_d = RX_IDLE;
            end
        endcase
    end

    // =========================================================================
    // Loader FSM
    // =========================================================================
    typedef enum logic [2:0] {
        L_IDLE,
        L_CNT_HI,
        L_CNT_LO,
        L_DATA_HI,
        L_DATA_LO,
        L_CHECK,
        L_ERROR
    } ld_state_t;

    ld_state_t             ld_state_q, ld_state_d;
    logic [15:0]           count_q, count_d;
    logic [7:0]            sum_q, sum_d;
    logic [7:0]            hi_q, hi_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [15:0]           rom_data_q, rom_data_d;
    logic                  rom_we_q, rom_we_d;
    logic                  cpu_reset_q, cpu_reset_d;
    logic                  loading_q, loading_d;
    logic [ADDR_WIDTH-1:0] word_count_q, word_count_d;
    logic                  frame_error_q, frame_error_d;
    logic                  chk_error_q, chk_error_d;

    logic [7:0]            rx_byte;
    logic [7:0]            sum_next;
    logic [16:0]           words_after_write;
    logic                  in_frame;

    assign rx_byte           = rx_shift_q;
    assign sum_next          = sum_q + rx_byte;
    assign words_after_write = 17'(word_count_q) + 17'd1;
    assign in_frame          = (ld_state_q == L_CNT_HI)  || (ld_state_q == L_CNT_LO) ||
                               (ld_state_q == L_DATA_HI) || (ld_state_q == L_DATA_LO) ||
                               (ld_state_q == L_CHECK);

    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state_q    <= L_IDLE;
            count_q       <= '0;
            sum_q         <= '0;
            hi_q          <= '0;
            rom_addr_q    <= '0;
            rom_data_q    <= '0;
            rom_we_q      <= 1'b0;
            cpu_reset_q   <= 1'b0;
            loading_q     <= 1'b0;
            word_count_q  <= '0;
            frame_error_q <= 1'b0;
            chk_error_q   <= 1'b0;
        end else begin
            ld_state_q    <= ld_state_d;
            count_q       <= count_d;
            sum_q         <= sum_d;
            hi_q          <= hi_d;
            rom_addr_q    <= rom_addr_d;
            rom_data_q    <= rom_data_d;
            rom_we_q      <= rom_we_d;
            cpu_reset_q   <= cpu_reset_d;
            loading_q     <= loading_d;
            word_count_q  <= word_count_d;
            frame_error_q <= frame_error_d;
            chk_error_q   <= chk_error_d;
        end
    end

    always_comb begin
        ld_state_d    = ld_state_q;
        count_d       = count_q;
        sum_d         = sum_q;
        hi_d          = hi_q;
        rom_addr_d    = rom_addr_q;
        rom_data_d    = rom_data_q;
        rom_we_d      = 1'b0;
        cpu_reset_d   = cpu_reset_q;
        loading_d     = loading_q;
        word_count_d  = word_count_q;
        frame_error_d = frame_error_q;
        chk_error_d   = chk_error_q;

        // Address and count advance on the edge that ends the write strobe,
        // keeping rom_addr stable for the whole rom_we cycle.
        if (rom_we_q) begin
            rom_addr_d   = rom_addr_q + 1'b1;
            word_count_d = word_count_q + 1'b1;
        end

        if (byte_err_q) begin
            frame_error_d = 1'b1;
            if (in_frame) begin
                ld_state_d = L_ERROR;
                loading_d  = 1'b0;
            end
        end else if (byte_valid_q) begin
            case (ld_state_q)
                L_IDLE, L_ERROR: begin
                    if (rx_byte == HEADER) begin
                        ld_state_d    = L_CNT_HI;
                        cpu_reset_d   = 1'b1;
                        loading_d     = 1'b1;
                        sum_d         = '0;
                        word_count_d  = '0;
                        rom_addr_d    = '0;
                        chk_error_d   = 1'b0;
                        frame_error_d = 1'b0;
                    end
                end

                // Counts of 32768 and above cannot be addressed.
                L_CNT_HI: begin
                    count_d[15:8] = rx_byte;
                    sum_d         = sum_next;
                    if (rx_byte[7]) begin
                        ld_state_d  = L_ERROR;
                        chk_error_d = 1'b1;
                        loading_d   = 1'b0;
                    end else begin
                        ld_state_d = L_CNT_LO;
                    end
                end

                L_CNT_LO: begin
                    count_d[7:0] = rx_byte;
                    sum_d        = sum_next;
                    ld_state_d   = ({count_q[15:8], rx_byte} == 16'd0) ? L_CHECK : L_DATA_HI;
                end

                L_DATA_HI: begin
                    hi_d       = rx_byte;
                    sum_d      = sum_next;
                    ld_state_d = L_DATA_LO;
                end

                L_DATA_LO: begin
                    sum_d      = sum_next;
                    rom_data_d = {hi_q, rx_byte};
                    rom_we_d   = 1'b1;
                    ld_state_d = (words_after_write == {1'b0, count_q}) ? L_CHECK : L_DATA_HI;
                end

                L_CHECK: begin
                    loading_d = 1'b0;
                    if (rx_byte == sum_q) begin
                        ld_state_d  = L_IDLE;
                        cpu_reset_d = 1'b0;
                    end else begin
                        ld_state_d  = L_ERROR;
                        chk_error_d = 1'b1;
                    end
                end

                default: begin
                    ld_state_d = L_IDLE;
                end
            endcase
        end
    end

    assign rom.rom_addr = rom_addr_q;
    assign rom.rom_data = rom_data_q;
    assign rom.rom_we   = rom_we_q;
    assign cpu_reset    = cpu_reset_q;
    assign loading      = loading_q;
    assign word_count   = word_count_q;
    assign frame_error  = frame_error_q;
    assign chk_error    = chk_error_q;

endmodule

// File: tb/tb_hack_program_loader.sv
// -----------------------------------------------------------------------------
// tb_hack_program_loader
//
// Directed frames are sent over rx. Each expected RAM write is queued when its
// frame is sent; a monitor pops and compares whenever rom_we is high. Status
// outputs are compared against hand-derived values after each frame.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_hack_program_loader;

    localparam int CPB = 8;
    localparam int AW  = 15;

    typedef struct {
        logic [AW-1:0] addr;
        logic [15:0]   data;
    } wr_t;

    typedef logic [7:0] byte_seq_t[$];

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx = 1'b1;
    logic          cpu_reset;
    logic          loading;
    logic [AW-1:0] word_count;
    logic          frame_error;
    logic          chk_error;

    int  pass_cnt = 0;
    int  total_cnt = 0;
    wr_t exp_q[$];

    hack_program_loader_if #(.ADDR_WIDTH(AW)) rom_if ();

    hack_program_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_WIDTH  (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .rom        (rom_if),
        .cpu_reset  (cpu_reset),
        .loading    (loading),
        .word_count (word_count),
        .frame_error(frame_error),
        .chk_error  (chk_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_clks(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap_bits);
        rx = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_clks(CPB);
        end
        rx = stop_bit;
        wait_clks(CPB);
        rx = 1'b1;
        wait_clks(gap_bits * CPB);
    endtask

    task automatic send_seq(input byte_seq_t seq, input int gap_bits);
        foreach (seq[i]) begin
            send_byte(seq[i], 1'b1, gap_bits);
        end
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [15:0] d);
        wr_t w;
        w.addr = a;
        w.data = d;
        exp_q.push_back(w);
    endtask

    task automatic check_status(input string tag, input logic exp_cpu_reset, input logic exp_loading,
                                input logic [AW-1:0] exp_wc, input logic exp_ferr, input logic exp_cerr);
        check({tag, "_cpu_reset"},   32'(cpu_reset),   32'(exp_cpu_reset));
        check({tag, "_loading"},     32'(loading),     32'(exp_loading));
        check({tag, "_word_count"},  32'(word_count),  32'(exp_wc));
        check({tag, "_frame_error"}, 32'(frame_error), 32'(exp_ferr));
        check({tag, "_chk_error"},   32'(chk_error),   32'(exp_cerr));
    endtask

    task automatic check_no_pending(input string tag);
        check({tag, "_writes_outstanding"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: every write strobe must match the next queued write, and the
    // CPU must be held in reset while its memory is being rewritten.
    always @(negedge clk) begin
        wr_t e;
        if (rom_if.rom_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write",
                         rom_if.rom_addr, rom_if.rom_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(rom_if.rom_addr), 32'(e.addr));
                check("wr_data", 32'(rom_if.rom_data), 32'(e.data));
                check("wr_cpu_reset", 32'(cpu_reset), 32'd1);
            end
        end
    end

    initial begin
        // Reset state
        wait_clks(4);
        check("rst_rom_addr", 32'(rom_if.rom_addr), 32'd0);
        check("rst_rom_data", 32'(rom_if.rom_data), 32'd0);
        check("rst_rom_we",   32'(rom_if.rom_we),   32'd0);
        check_status("rst", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        wait_clks(3 * CPB);

        // Leading junk ignored; empty frame (CHK = 0x00) pulses cpu_reset
        send_seq('{8'h12, 8'h34}, 2);
        check_status("junk", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        send_byte(8'hA5, 1'b1, 2);
        check_status("n0_hdr", 1'b1, 1'b1, '0, 1'b0, 1'b0);
        send_seq('{8'h00, 8'h00, 8'h00}, 2);
        check_status("n0_end", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_no_pending("n0");

        // Two-word frame, bytes back-to-back with a single stop bit.
        // CHK = 00+02+EC+10+00+03 = 0x101 -> 0x01
        expect_write(15'd0, 16'hEC10);
        expect_write(15'd1, 16'h0003);
        send_seq('{8'hA5, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h03, 8'h01}, 0);
        wait_clks(3 * CPB);
        check_status("b2b", 1'b0, 1'b0, 15'd2, 1'b0, 1'b0);
        check("b2b_rom_addr", 32'(rom_if.rom_addr), 32'd2);
        check_no_pending("b2b");

        // Same frame with a wrong checksum, then recovery with the good one
        expect_write(15'd0, 16'hEC10);
        expect_write(15'd1, 16'h0003);
        send_seq('{8'hA5, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h03, 8'h00}, 2);
        check_status("badchk", 1'b1, 1'b0, 15'd2, 1'b0, 1'b1);
        check_no_pending("badchk");
        expect_write(15'd0, 16'hEC10);
        expect_write(15'd1, 16'h0003);
        send_seq('{8'hA5, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00, 8'h03, 8'h01}, 2);
        check_status("recover", 1'b0, 1'b0, 15'd2, 1'b0, 1'b0);
        check_no_pending("recover");

        // Header then a byte with a low stop bit: load aborted, later bytes ignored
        send_byte(8'hA5, 1'b1, 2);
        send_byte(8'h00, 1'b0, 2);
        check_status("ferr", 1'b1, 1'b0, '0, 1'b1, 1'b0);
        send_seq('{8'h00, 8'h01, 8'hAB, 8'hCD, 8'h79}, 2);
        check_status("ferr_after", 1'b1, 1'b0, '0, 1'b1, 1'b0);
        check_no_pending("ferr");

        // Illegal count (bit 7 of COUNT_HI set); header clears frame_error
        send_seq('{8'hA5, 8'h80}, 2);
        check_status("cnt80", 1'b1, 1'b0, '0, 1'b0, 1'b1);
        send_seq('{8'h00, 8'h01, 8'h12, 8'h34}, 2);
        check_status("cnt80_after", 1'b1, 1'b0, '0, 1'b0, 1'b1);
        check_no_pending("cnt80");

        // Reset during the second data word: first write stays, no second write
        expect_write(15'd0, 16'hEC10);
        send_seq('{8'hA5, 8'h00, 8'h02, 8'hEC, 8'h10, 8'h00}, 2);
        check_status("mid", 1'b1, 1'b1, 15'd1, 1'b0, 1'b0);
        check("mid_rom_addr", 32'(rom_if.rom_addr), 32'd1);
        reset = 1'b1;
        wait_clks(1);
        check("mrst_rom_addr", 32'(rom_if.rom_addr), 32'd0);
        check("mrst_rom_data", 32'(rom_if.rom_data), 32'd0);
        check("mrst_rom_we",   32'(rom_if.rom_we),   32'd0);
        check_status("mrst", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        reset = 1'b0;
        wait_clks(2 * CPB);
        send_seq('{8'h03, 8'h01}, 2);
        check_status("mrst_after", 1'b0, 1'b0, '0, 1'b0, 1'b0);
        check_no_pending("mrst");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
